// File: rtl/lfsr_stream_if.sv
// lfsr_stream_if: control and result signals of one lfsr_stream instance.
// The master drives enable/seed/mode and observes state, random bits and status.
interface lfsr_stream_if #(
  parameter int LEN  = 8,
  parameter int STEP = 1
);
  logic            en;
  logic            seed_ld;
  logic [LEN-1:0]  seed;
  logic            mode;
  logic [LEN-1:0]  sreg;
  logic [STEP-1:0] rnd;
  logic            valid;
  logic            wrap;
  logic            lockup;
  logic [LEN-1:0]  period;

  modport master (
    output en, seed_ld, seed, mode,
    input  sreg, rnd, valid, wrap, lockup, period
  );

  modport slave (
    input  en, seed_ld, seed, mode,
    output sreg, rnd, valid, wrap, lockup, period
  );
endinterface

// File: rtl/lfsr_stream.sv
// lfsr_stream: STEP shifts of a Galois/Fibonacci LFSR per en, 1-cycle latency, no backpressure.
// Optional LFSR_PERIOD_EN adds a sequence-period counter; without it period is tied to 0.
module lfsr_stream #(
  parameter int             LEN       = 8,
  parameter logic [LEN-1:0] TAPS      = LEN'(8'b10111000),
  parameter int             STEP      = 1,
  parameter logic [LEN-1:0] SAFE_SEED = LEN'(1)
) (
  input logic          clk,
  input logic          rst,
  lfsr_stream_if.slave bus
);

  function automatic logic [LEN-1:0] bitrev(input logic [LEN-1:0] v);
    logic [LEN-1:0] r;
    r = '0;
    for (int i = 0; i < LEN; i++) begin
      r[i] = v[LEN-1-i];
    end
    return r;
  endfunction

  localparam logic [LEN-1:0] FIB_MASK = bitrev(TAPS);

  logic [LEN-1:0]  sreg_q;
  logic [LEN-1:0]  seed_q;
  logic [STEP-1:0] rnd_q;
  logic            valid_q;
  logic            wrap_q;
  logic            lockup_q;

  logic [LEN-1:0]  load_val;
  logic            seed_zero;
  logic [LEN-1:0]  adv_state;
  logic [STEP-1:0] adv_rnd;
  logic            adv_wrap;

  // A zero seed would freeze the register, so it is replaced on every load path.
  assign seed_zero = (bus.seed == '0);
  assign load_val  = seed_zero ? SAFE_SEED : bus.seed;

  // STEP single shifts unrolled into one combinational cone.
  always_comb begin
    logic [LEN-1:0] s;
    s       = sreg_q;
    adv_rnd = '0;
    for (int k = 0; k < STEP; k++) begin
      adv_rnd[k] = s[0];
      if (!bus.mode) begin
        s = {1'b0, s[LEN-1:1]} ^ (s[0] ? TAPS : '0);
      end else begin
        s = {^(s & FIB_MASK), s[LEN-1:1]};
      end
    end
    adv_state = s;
  end

  assign adv_wrap = (adv_state == seed_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg_q   <= load_val;
      seed_q   <= load_val;
      lockup_q <= seed_zero;
      rnd_q    <= '0;
      valid_q  <= 1'b0;
      wrap_q   <= 1'b0;
    end else if (bus.seed_ld) begin
      sreg_q   <= load_val;
      seed_q   <= load_val;
      lockup_q <= seed_zero;
      valid_q  <= 1'b0;
      wrap_q   <= 1'b0;
    end else if (bus.en) begin
      sreg_q   <= adv_state;
      rnd_q    <= adv_rnd;
      valid_q  <= 1'b1;
      wrap_q   <= adv_wrap;
    end else begin
      valid_q  <= 1'b0;
      wrap_q   <= 1'b0;
    end
  end

`ifdef LFSR_PERIOD_EN
  logic [LEN-1:0] cnt_q;
  logic [LEN-1:0] period_q;
  logic [LEN-1:0] cnt_inc;

  // Saturates so a sequence longer than the counter reports all-ones, never a small bogus value.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      period_q <= '0;
    end else if (bus.seed_ld) begin
      cnt_q    <= '0;
    end else if (bus.en) begin
      if (adv_wrap) begin
        period_q <= cnt_inc;
        cnt_q    <= '0;
      end else begin
        cnt_q    <= cnt_inc;
      end
    end
  end

  assign bus.period = period_q;
`else
  assign bus.period = '0;
`endif

  assign bus.sreg   = sreg_q;
  assign bus.rnd    = rnd_q;
  assign bus.valid  = valid_q;
  assign bus.wrap   = wrap_q;
  assign bus.lockup = lockup_q;

endmodule

// File: tb/tb_lfsr_stream.sv
// Directed bench for lfsr_stream: a STEP=1 and a STEP=4 instance share stimulus.
module tb_lfsr_stream;
  logic       clk;
  logic       rst;
  logic       en;
  logic       seed_ld;
  logic [7:0] seed;
  logic       mode;
  int         n_tests;
  int         n_fail;

  lfsr_stream_if #(.LEN(8), .STEP(1)) b1 ();
  lfsr_stream_if #(.LEN(8), .STEP(4)) b4 ();

  assign b1.en = en;  assign b1.seed_ld = seed_ld;  assign b1.seed = seed;  assign b1.mode = mode;
  assign b4.en = en;  assign b4.seed_ld = seed_ld;  assign b4.seed = seed;  assign b4.mode = mode;

  lfsr_stream #(.LEN(8), .TAPS(8'hB8), .STEP(1), .SAFE_SEED(8'h01)) u1 (.clk(clk), .rst(rst), .bus(b1));
  lfsr_stream #(.LEN(8), .TAPS(8'hB8), .STEP(4), .SAFE_SEED(8'h01)) u4 (.clk(clk), .rst(rst), .bus(b4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [7:0] s);
    rst = 1'b1; en = 1'b0; seed_ld = 1'b0; seed = s;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    mode = 1'b0;
    do_reset(8'h00);
    n_tests++; if (b1.sreg !== 8'h01) begin n_fail++; $display("FAIL reset_zero_sreg: got %h want 01", b1.sreg); end
    n_tests++; if (b1.lockup !== 1'b1) begin n_fail++; $display("FAIL reset_zero_lockup: got %b want 1", b1.lockup); end
    n_tests++; if ({b1.valid, b1.wrap, b1.rnd} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {b1.valid, b1.wrap, b1.rnd}); end
    n_tests++; if (b1.period !== 8'h00) begin n_fail++; $display("FAIL reset_period: got %h want 00", b1.period); end
    do_reset(8'h01);
    n_tests++; if ({b1.sreg, b1.lockup} !== {8'h01, 1'b0}) begin n_fail++; $display("FAIL reset_seed01: got %h/%b want 01/0", b1.sreg, b1.lockup); end
  endtask

  task automatic test_galois();
    logic [7:0] exp_s [5];
    logic       exp_r [5];
    exp_s = '{8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};
    exp_r = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    mode = 1'b0;
    do_reset(8'h01);
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++;
      if ({b1.sreg, b1.rnd, b1.valid} !== {exp_s[i], exp_r[i], 1'b1}) begin
        n_fail++;
        $display("FAIL galois_step%0d: got sreg=%h rnd=%b valid=%b want sreg=%h rnd=%b valid=1", i, b1.sreg, b1.rnd, b1.valid, exp_s[i], exp_r[i]);
      end
    end
    en = 1'b0;
    tick();
    n_tests++; if ({b1.sreg, b1.valid} !== {8'hB3, 1'b0}) begin n_fail++; $display("FAIL galois_hold: got %h/%b want b3/0", b1.sreg, b1.valid); end
  endtask

  task automatic test_fibonacci();
    int wraps;
    int wrap_at;
    mode = 1'b1;
    do_reset(8'h01);
    en = 1'b1;
    tick();
    n_tests++; if (b1.sreg !== 8'h80) begin n_fail++; $display("FAIL fib_step0: got %h want 80", b1.sreg); end
    tick();
    n_tests++; if (b1.sreg !== 8'h40) begin n_fail++; $display("FAIL fib_step1: got %h want 40", b1.sreg); end
    do_reset(8'h01);
    en = 1'b1;
    wraps = 0; wrap_at = 0;
    for (int i = 1; i <= 255; i++) begin
      tick();
      if (b1.wrap === 1'b1) begin wraps++; wrap_at = i; end
    end
    en = 1'b0;
    n_tests++; if (wraps !== 1 || wrap_at !== 255) begin n_fail++; $display("FAIL fib_wrap: got %0d pulses last at %0d want 1 at 255", wraps, wrap_at); end
    n_tests++; if (b1.sreg !== 8'h01) begin n_fail++; $display("FAIL fib_wrap_state: got %h want 01", b1.sreg); end
  endtask

  task automatic test_step4();
    mode = 1'b0;
    do_reset(8'h01);
    en = 1'b1;
    tick();
    en = 1'b0;
    n_tests++; if ({b4.sreg, b4.rnd, b4.valid} !== {8'h17, 4'b0001, 1'b1}) begin n_fail++; $display("FAIL step4_adv: got sreg=%h rnd=%b valid=%b want 17/0001/1", b4.sreg, b4.rnd, b4.valid); end
    tick();
    n_tests++; if ({b4.sreg, b4.valid} !== {8'h17, 1'b0}) begin n_fail++; $display("FAIL step4_pulse: got %h/%b want 17/0", b4.sreg, b4.valid); end
  endtask

  task automatic test_seed_load();
    mode = 1'b0;
    do_reset(8'h01);
    seed_ld = 1'b1; seed = 8'h00;
    tick();
    n_tests++; if ({b1.sreg, b1.lockup, b1.valid} !== {8'h01, 1'b1, 1'b0}) begin n_fail++; $display("FAIL load_zero: got %h/%b/%b want 01/1/0", b1.sreg, b1.lockup, b1.valid); end
    seed = 8'h5A;
    tick();
    n_tests++; if ({b1.sreg, b1.lockup} !== {8'h5A, 1'b0}) begin n_fail++; $display("FAIL load_5a: got %h/%b want 5a/0", b1.sreg, b1.lockup); end
    seed_ld = 1'b0; en = 1'b1;
    tick(); tick();
    n_tests++; if ({b1.sreg, b1.rnd} !== {8'hAE, 1'b1}) begin n_fail++; $display("FAIL load_then_adv: got %h/%b want ae/1", b1.sreg, b1.rnd); end
    seed_ld = 1'b1; seed = 8'h33;
    tick();
    seed_ld = 1'b0; en = 1'b0;
    n_tests++; if ({b1.sreg, b1.valid, b1.rnd} !== {8'h33, 1'b0, 1'b1}) begin n_fail++; $display("FAIL load_over_en: got sreg=%h valid=%b rnd=%b want 33/0/1", b1.sreg, b1.valid, b1.rnd); end
  endtask

  task automatic test_period();
    logic [7:0] exp_p;
`ifdef LFSR_PERIOD_EN
    exp_p = 8'd255;
`else
    exp_p = 8'd0;
`endif
    mode = 1'b0;
    do_reset(8'h01);
    en = 1'b1;
    for (int i = 0; i < 254; i++) tick();
    n_tests++; if (b1.period !== 8'd0) begin n_fail++; $display("FAIL period_pre_wrap: got %0d want 0", b1.period); end
    tick();
    n_tests++; if ({b1.period, b1.wrap} !== {exp_p, 1'b1}) begin n_fail++; $display("FAIL period_first: got %0d/%b want %0d/1", b1.period, b1.wrap, exp_p); end
    for (int i = 0; i < 255; i++) tick();
    n_tests++; if ({b1.period, b1.wrap} !== {exp_p, 1'b1}) begin n_fail++; $display("FAIL period_second: got %0d/%b want %0d/1", b1.period, b1.wrap, exp_p); end
    for (int i = 0; i < 7; i++) tick();
    do_reset(8'h77);
    n_tests++; if ({b1.period, b1.sreg} !== {8'd0, 8'h77}) begin n_fail++; $display("FAIL period_reset: got %0d/%h want 0/77", b1.period, b1.sreg); end
  endtask

  task automatic test_mode_switch();
    logic [7:0] exp_s [3];
    logic       exp_r [3];
    exp_s = '{8'hAE, 8'h57, 8'hAB};
    exp_r = '{1'b0, 1'b0, 1'b1};
    mode = 1'b0;
    do_reset(8'h01);
    en = 1'b1;
    tick(); tick();
    n_tests++; if (b1.sreg !== 8'h5C) begin n_fail++; $display("FAIL switch_pre: got %h want 5c", b1.sreg); end
    mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if ({b1.sreg, b1.rnd, b1.valid} !== {exp_s[i], exp_r[i], 1'b1}) begin
        n_fail++;
        $display("FAIL switch_step%0d: got sreg=%h rnd=%b valid=%b want sreg=%h rnd=%b valid=1", i, b1.sreg, b1.rnd, b1.valid, exp_s[i], exp_r[i]);
      end
    end
    en = 1'b0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst = 1'b1; en = 1'b0; seed_ld = 1'b0; seed = 8'h01; mode = 1'b0;
    test_reset();
    test_galois();
    test_fibonacci();
    test_step4();
    test_seed_load();
    test_period();
    test_mode_switch();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/lfsr_stream.md
Name: lfsr_stream

Overview:
Parametrised pseudo-random generator for the Aznable system. It advances a LEN-bit LFSR by STEP shifts per enable and supports Galois or Fibonacci form, selectable at runtime. It also handles run-time reseeding, substitutes a non-zero state for a zero seed (lock-up protection), and flags sequence wrap. It feeds starfield, noise and dither logic that needs several fresh bits per pixel clock.

Parameters:
LEN, 8, register width in bits (4..32)
TAPS, 8'b10111000, Galois XOR tap mask. The Fibonacci feedback mask is bit-reverse(TAPS).
STEP, 1, shifts applied per enable (1..LEN), unrolled combinationally
SAFE_SEED, 1, value loaded instead of an all-zero seed

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
en  in  1  advance STEP shifts this cycle
seed_ld  in  1  load seed this cycle
seed  in  LEN  seed value
mode  in  1  0 = Galois, 1 = Fibonacci
sreg  out  LEN  current LFSR state
rnd  out  STEP  bits shifted out by the last advance; bit0 is the first shifted
valid  out  1  one-cycle pulse: sreg/rnd updated by an advance
wrap  out  1  one-cycle pulse: the advanced state equals the stored seed
lockup  out  1  sticky: a zero seed was substituted
period  out  LEN  enables per cycle of the sequence (see Optional Feature)

Behaviour:
- Single step, Galois: out = s[0]; s' = {0, s[LEN-1:1]} XOR (s[0] ? TAPS : 0).
- Single step, Fibonacci: out = s[0]; fb = parity(s AND bitrev(TAPS)); s' = {fb, s[LEN-1:1]}.
- An advance applies STEP single steps in sequence within one cycle. Result is registered at the edge where en=1.
- rnd[k] = out bit of step k. valid=1 in the following cycle; 0 otherwise.
- Reset (rst=1), which overrides all other inputs:
  - sreg <= (seed==0 ? SAFE_SEED : seed); seed_reg <= the same value.
  - lockup <= (seed==0).
  - rnd=0, valid=0, wrap=0, period=0, internal counter=0.
- seed_ld=1 (rst=0):
  - Same load as reset, except rnd and period are held.
  - seed_ld has priority over en; the en in that cycle is ignored and no valid pulse is produced.
  - lockup clears on a non-zero load.
- wrap: registered alongside valid. It is 1 when the post-advance state == seed_reg.
  - Only step-boundary states are compared. With STEP coprime to the period, wrap fires every period enables.
- mode change takes effect at the next advance. State is preserved; no reload occurs.
- en=0 and seed_ld=0: all state is held; valid=0, wrap=0.
- The all-zero state is unreachable through load. sreg==0 can never occur, so no further lock-up handling is needed.

Optional Feature:
Macro LFSR_PERIOD_EN.
- Defined:
  - A LEN-bit counter increments on each advance.
  - On a wrap advance, period <= counter+1 and the counter clears.
  - Load or reset clears the counter. Load holds period; reset clears it.
  - The counter saturates at all-ones without wrapping.
- Not defined: no counter; period is tied to 0.

Test Plan:
1. LEN=8, STEP=1, Galois, rst with seed=0x01, then 5 enables -> sreg 0xB8, 0x5C, 0x2E, 0x17, 0xB3. rnd 1,0,0,0,1. valid high one cycle after each en.
2. Same config, mode=1, seed 0x01, 2 enables -> sreg 0x80, then 0x40. 255 enables from seed -> wrap pulses exactly on enable 255.
3. STEP=4, Galois, seed 0x01, one enable -> sreg 0x17, rnd 4'b0001, single valid pulse.
4. seed_ld with seed=0x00 -> sreg 0x01, lockup=1. Then seed_ld with 0x5A -> sreg 0x5A, lockup=0. seed_ld and en in the same cycle -> sreg == seed, valid=0.
5. LFSR_PERIOD_EN defined, STEP=1, seed 0x01, 510 enables -> period=255 after first wrap and stays 255 after the second. rst mid-sequence -> period=0, sreg=seed.
6. Galois mid-run: switch mode to 1 while en held for 3 cycles -> the first post-switch advance uses Fibonacci feedback from the held state, with no reload and no glitch on valid.
